rom_addr_seq: RTL
=================

Name: rom_addr_seq

Overview:
- Address sequencer directly upstream of the classifier ROM read port.
- Accepts burst commands {count, base} on a dti consumer interface and emits `count` consecutive ROM addresses on a dti producer interface.
- The producer interface connects straight to the ROM's rd_addr_if.
- Each address carries a `last` flag so downstream stages can delimit a stage's feature set.

Parameters:
W_ADDR, 16, width of generated ROM address
W_CNT, 10, width of burst length field (max burst 2^W_CNT-1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_if  dti.consumer  W_CNT+W_ADDR  command; data = {count[W_CNT-1:0], base[W_ADDR-1:0]}
addr_if  dti.producer  W_ADDR+1  address beat; data = {last, addr[W_ADDR-1:0]}
busy_o  output  1  high while a burst is in progress (RUN state)

Behaviour:
- Interfaces:
  - dti semantics: transfer occurs on a cycle with valid && ready.
  - Producer holds valid and data stable until the transfer occurs.
  - Producer never deasserts valid without a transfer.
- Reset: applied on rising edge with rst=1.
  - State=IDLE.
  - addr_if.valid=0, addr_if.data=0.
  - cmd_if.ready=0 during the reset cycle, 1 in the first cycle after reset is released.
  - busy_o=0; internal addr and remaining counters = 0.
- State machine: IDLE, RUN.
- IDLE:
  - cmd_if.ready=1, addr_if.valid=0, busy_o=0.
  - On cmd transfer with count!=0: load addr_r=base, rem_r=count, go RUN.
  - On cmd transfer with count==0: command consumed, no address emitted, stay IDLE.
- RUN:
  - cmd_if.ready=0, busy_o=1, addr_if.valid=1.
  - addr_if.data={rem_r==1, addr_r}.
  - On addr transfer with rem_r>1: addr_r <= addr_r+1, rem_r <= rem_r-1.
  - On addr transfer with rem_r==1: go IDLE.
  - With addr_if.ready=0: hold all state; valid and data unchanged.
- Latency:
  - First address is valid in the cycle after cmd acceptance (registered output; no combinational path cmd→addr).
  - With ready held high, one address per cycle.
  - One IDLE cycle between consecutive bursts: next cmd accepted no earlier than the cycle after the last beat's transfer.
- Arithmetic:
  - addr_r increments modulo 2^W_ADDR; base+count overflowing wraps to 0, with no error flag.
  - rem_r is W_CNT wide; count=2^W_CNT-1 is the maximum burst.
- No combinational path from addr_if.ready to cmd_if.ready or to addr_if.valid.
- Reset mid-burst aborts the burst: the next cycle has valid=0 and state IDLE. Remaining addresses are discarded.
- Interface data outputs are registered. addr_if.data may hold a stale value when valid=0; the bench must not check it then.

Test Plan:
- Single burst: cmd {count=4, base=0x0010}, ready=1 → beats 0x0010,0x0011,0x0012,0x0013; last=1 only on 0x0013. First valid one cycle after cmd transfer; busy_o high for 4 cycles.
- Backpressure: cmd {count=3, base=0x0100}, ready toggled 1,0,0,1,0,1 → exactly 3 transfers 0x0100,0x0101,0x0102. Data stable during each ready=0 cycle; no duplicated or dropped beats.
- Zero count and back-to-back: cmd {0,0x0050}, then cmd {2,0x0020} → nothing emitted for the first. Then 0x0020, 0x0021(last). A third cmd is not accepted in the cycle of the 0x0021 transfer; it is accepted the next cycle.
- Wrap: W_ADDR=16, cmd {count=3, base=0xFFFE} → 0xFFFE, 0xFFFF, 0x0000(last).
- Reset mid-burst: cmd {count=8, base=0x0200}, assert rst after the 3rd transfer → cycle after reset: valid=0, busy_o=0. A new cmd {1,0x0300} yields a single beat 0x0300 with last=1.
- Max burst: cmd {count=1023, base=0x0000}, ready random at 50% → 1023 beats 0x0000..0x03FE in order; last only on 0x03FE; returns to IDLE.

Source files
------------

// File: rtl/rom_addr_seq.sv
// Purpose: expands {count, base} burst commands into consecutive ROM read addresses tagged with a last flag.
// Latency: first address valid the cycle after command acceptance, then one address per cycle while ready.
// Backpressure: addr_rdy low holds address/flag stable; cmd_rdy only in IDLE, so a new burst waits for the previous one.
module rom_addr_seq #(
  parameter int W_ADDR = 16,
  parameter int W_CNT  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  // command consumer: data = {count, base}
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  input  logic [W_CNT+W_ADDR-1:0] cmd_dat,
  // address producer: data = {last, addr}
  output logic                    addr_vld,
  input  logic                    addr_rdy,
  output logic [W_ADDR:0]         addr_dat,
  output logic                    busy_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W_CNT-1:0] CNT_ZERO = '0;
  localparam logic [W_CNT-1:0] CNT_ONE  = W_CNT'(1);
  localparam logic [W_CNT-1:0] CNT_TWO  = W_CNT'(2);

  state_t              state;
  logic [W_ADDR-1:0]   addr_r;
  logic [W_CNT-1:0]    rem_r;
  logic                last_r;
  logic                vld_r;
  logic                busy_r;

  logic [W_CNT-1:0]    cmd_cnt;
  logic [W_ADDR-1:0]   cmd_base;
  logic                cmd_fire;
  logic                addr_fire;

  assign cmd_cnt  = cmd_dat[W_CNT+W_ADDR-1:W_ADDR];
  assign cmd_base = cmd_dat[W_ADDR-1:0];

  // Ready depends only on state and reset, never on addr_rdy; reset forces it low in the reset cycle.
  assign cmd_rdy   = (state == IDLE) && !rst;
  assign cmd_fire  = cmd_vld && cmd_rdy;
  assign addr_fire = vld_r && addr_rdy;

  assign addr_vld = vld_r;
  assign addr_dat = {last_r, addr_r};
  assign busy_o   = busy_r;

  // Burst FSM: loads on command, steps the address per accepted beat, returns to IDLE after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_r <= '0;
      rem_r  <= '0;
      last_r <= 1'b0;
      vld_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-length command is consumed without producing any beat.
          if (cmd_fire && (cmd_cnt != CNT_ZERO)) begin
            state  <= RUN;
            addr_r <= cmd_base;
            rem_r  <= cmd_cnt;
            last_r <= (cmd_cnt == CNT_ONE);
            vld_r  <= 1'b1;
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          if (addr_fire) begin
            if (rem_r == CNT_ONE) begin
              state  <= IDLE;
              rem_r  <= CNT_ZERO;
              last_r <= 1'b0;
              vld_r  <= 1'b0;
              busy_r <= 1'b0;
            end else begin
              // Address wraps modulo 2^W_ADDR by plain truncation.
              addr_r <= addr_r + W_ADDR'(1);
              rem_r  <= rem_r - CNT_ONE;
              last_r <= (rem_r == CNT_TWO);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
